alu_arbiter: RTL and testbench

Shares one ALU instance between two requesters (e.g. the main datapath port and an address/auxiliary unit) using round-robin arbitration and valid/ready handshakes on both the request and response sides. The block registers the granted operands and opcode, evaluates them in the internal ALU, registers the result, and holds it until the owning requester accepts it. It sits between the requesters and the ALU; the requesters never drive the ALU directly.

---
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// Requester k uses the signals suffixed with k; the result bus is shared.
interface alu_arbiter_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;

   logic              req_valid0;
   logic              req_valid1;
   logic              req_ready0;
   logic              req_ready1;
   logic [DATA_W-1:0] req_a0;
   logic [DATA_W-1:0] req_a1;
   logic [DATA_W-1:0] req_b0;
   logic [DATA_W-1:0] req_b1;
   logic [OP_W-1:0]   req_op0;
   logic [OP_W-1:0]   req_op1;
   logic              resp_valid0;
   logic              resp_valid1;
   logic              resp_ready0;
   logic              resp_ready1;
   logic [DATA_W-1:0] resp_result;
   logic              resp_zero;

   modport slave (
      input  req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1,
             req_op0, req_op1, resp_ready0, resp_ready1,
      output req_ready0, req_ready1, resp_valid0, resp_valid1,
             resp_result, resp_zero
   );

   modport master (
      output req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1,
             req_op0, req_op1, resp_ready0, resp_ready1,
      input  req_ready0, req_ready1, resp_valid0, resp_valid1,
             resp_result, resp_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation in
// flight at a time (IDLE -> EXEC -> RESP), result held until the owner accepts.
module alu_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     bus,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [OP_W-1:0]   op_q;
   logic              owner_q;
   logic              last_grant_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] alu_c;
   logic              grant1_c;
   logic              accept_c;
   logic              handshake_c;

   // Shared ALU on the registered operands
   always_comb begin
      alu_c = '0;
      unique case (op_q)
         3'b000:  alu_c = a_q & b_q;
         3'b001:  alu_c = a_q | b_q;
         3'b010:  alu_c = a_q + b_q;
         3'b100:  alu_c = a_q - b_q;
         3'b101:  alu_c = a_q * b_q;
         3'b110:  alu_c = DATA_W'(a_q < b_q);
         default: alu_c = '0;
      endcase
   end

   // Next state, arbitration and handshake decode
   always_comb begin
      state_nxt       = state;
      accept_c        = 1'b0;
      handshake_c     = 1'b0;
      bus.req_ready0  = 1'b0;
      bus.req_ready1  = 1'b0;
      bus.resp_valid0 = 1'b0;
      bus.resp_valid1 = 1'b0;
      // requester 1 wins alone, or on a tie when requester 0 was granted last
      grant1_c = bus.req_valid1 & (~bus.req_valid0 | ~last_grant_q);
      unique case (state)
         IDLE: begin
            if (bus.req_valid0 | bus.req_valid1) begin
               accept_c       = 1'b1;
               bus.req_ready0 = ~grant1_c;
               bus.req_ready1 = grant1_c;
               state_nxt      = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            bus.resp_valid0 = ~owner_q;
            bus.resp_valid1 = owner_q;
            if (owner_q ? bus.resp_ready1 : bus.resp_ready0) begin
               handshake_c = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand capture, result register and completion counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         result_q     <= '0;
         zero_q       <= 1'b1;
         cnt_q        <= '0;
      end else begin
         if (accept_c) begin
            a_q          <= grant1_c ? bus.req_a1  : bus.req_a0;
            b_q          <= grant1_c ? bus.req_b1  : bus.req_b0;
            op_q         <= grant1_c ? bus.req_op1 : bus.req_op0;
            owner_q      <= grant1_c;
            last_grant_q <= grant1_c;
         end
         if (state == EXEC) begin
            result_q <= alu_c;
            zero_q   <= ~|alu_c;
         end
         if (handshake_c) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.resp_result = result_q;
   assign bus.resp_zero   = zero_q;
   assign busy            = (state != IDLE);
   assign op_count        = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of grants, latencies and results.
module tb_alu_arbiter;
   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   alu_arbiter_if bus();

   alu_arbiter #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd4:    return a - b;
         3'd5:    return a * b;
         3'd6:    return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Reference model: one operation outstanding, accepted in cycle acc_cyc,
   // result visible from acc_cyc+2 until the owner takes it.
   bit          inflight;
   bit          own;
   bit          last_g;
   int          cyc = 0;
   int          acc_cyc;
   int          exp_cnt;
   logic [31:0] ma, mb, shown_res;
   logic [2:0]  mop;
   bit          shown_zero;
   bit          got0, got1;
   bit          any_req, win, resp_on, exec_on;
   int          gq[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         inflight = 1'b0; exp_cnt = 0; last_g = 1'b1;
         shown_res = 32'd0; shown_zero = 1'b1; got0 = 1'b0; got1 = 1'b0;
         chk("rst_req_ready0", bus.req_ready0, 0);
         chk("rst_req_ready1", bus.req_ready1, 0);
         chk("rst_resp_valid0", bus.resp_valid0, 0);
         chk("rst_resp_valid1", bus.resp_valid1, 0);
         chk("rst_busy", busy, 0);
         chk("rst_result", bus.resp_result, 0);
         chk("rst_zero", bus.resp_zero, 1);
         chk("rst_op_count", op_count, 0);
      end else begin
         cyc++;
         any_req = !inflight && (bus.req_valid0 || bus.req_valid1);
         win     = (bus.req_valid0 && bus.req_valid1) ? !last_g : bus.req_valid1;
         resp_on = inflight && (cyc >= acc_cyc + 2);
         exec_on = inflight && (cyc == acc_cyc + 1);
         chk("req_ready0", bus.req_ready0, any_req && !win);
         chk("req_ready1", bus.req_ready1, any_req && win);
         chk("resp_valid0", bus.resp_valid0, resp_on && !own);
         chk("resp_valid1", bus.resp_valid1, resp_on && own);
         chk("busy", busy, exec_on || resp_on);
         chk("resp_result", bus.resp_result, shown_res);
         chk("resp_zero", bus.resp_zero, shown_zero);
         chk("op_count", op_count, 32'(exp_cnt));
         got0 = any_req && !win;
         got1 = any_req && win;
         if (any_req) begin
            inflight = 1'b1; acc_cyc = cyc; own = win; last_g = win;
            ma  = win ? bus.req_a1  : bus.req_a0;
            mb  = win ? bus.req_b1  : bus.req_b0;
            mop = win ? bus.req_op1 : bus.req_op0;
            gq.push_back(int'(win));
         end else if (exec_on) begin
            shown_res  = alu_ref(ma, mb, mop);
            shown_zero = (shown_res == 32'd0);
         end else if (resp_on && (own ? bus.resp_ready1 : bus.resp_ready0)) begin
            inflight = 1'b0;
            exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit k, input bit v, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op);
      if (k) begin
         bus.req_valid1 = v; bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
      end else begin
         bus.req_valid0 = v; bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
      end
   endtask

   task automatic wait_ready(input bit k);
      bit hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (k ? bus.req_ready1 : bus.req_ready0) begin
            hit = 1'b1;
            break;
         end
      end
      chk("wait_req_ready", hit, 1);
      tick();
   endtask

   task automatic wait_resp(input bit k, output logic [31:0] res, output logic z);
      bit hit = 1'b0;
      res = 'x; z = 1'bx;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (k ? bus.resp_valid1 : bus.resp_valid0) begin
            hit = 1'b1; res = bus.resp_result; z = bus.resp_zero;
            break;
         end
      end
      chk("wait_resp_valid", hit, 1);
      tick();
   endtask

   task automatic run_op(input bit k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, output logic [31:0] res, output logic z);
      if (k) bus.resp_ready1 = 1'b1; else bus.resp_ready0 = 1'b1;
      set_req(k, 1'b1, a, b, op);
      wait_ready(k);
      set_req(k, 1'b0, a, b, op);
      wait_resp(k, res, z);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      set_req(1'b0, 1'b0, '0, '0, '0);
      set_req(1'b1, 1'b0, '0, '0, '0);
      bus.resp_ready0 = 1'b0;
      bus.resp_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 3))
         0:       return 32'd0;
         1:       return 32'($urandom_range(0, 15));
         2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   logic [31:0] res;
   logic        z;
   logic [31:0] sweep_exp [8] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0,
                                  32'd4, 32'hFFFF_FFFD, 32'd1, 32'd0};
   int          wrap_exp [5] = '{1, 2, 3, 0, 1};

   initial begin
      do_reset();

      // Single op on requester 0: 7 + 5
      bus.resp_ready0 = 1'b1;
      set_req(1'b0, 1'b1, 32'd7, 32'd5, 3'b010);
      @(negedge clk);
      chk("t1_req_ready0", bus.req_ready0, 1);
      tick();
      set_req(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk("t1_exec_no_resp", bus.resp_valid0, 0);
      tick();
      @(negedge clk);
      chk("t1_resp_valid0", bus.resp_valid0, 1);
      chk("t1_result", bus.resp_result, 32'd12);
      chk("t1_zero", bus.resp_zero, 0);
      chk("t1_resp_valid1", bus.resp_valid1, 0);
      tick();
      @(negedge clk);
      chk("t1_op_count", op_count, 1);
      tick();

      // Tie arbitration with both requesters held valid
      do_reset();
      gq.delete();
      bus.resp_ready0 = 1'b1;
      bus.resp_ready1 = 1'b1;
      set_req(1'b0, 1'b1, 32'd9, 32'd9, 3'b100);
      set_req(1'b1, 1'b1, 32'hF0, 32'h0F, 3'b000);
      for (int i = 0; i < 40 && gq.size() < 4; i++) tick();
      set_req(1'b0, 1'b0, '0, '0, '0);
      set_req(1'b1, 1'b0, '0, '0, '0);
      chk("tie_grant_count", 32'(gq.size() >= 4), 1);
      for (int i = 0; i < 4 && i < gq.size(); i++) chk("tie_grant_order", 32'(gq[i]), 32'(i % 2));
      repeat (4) tick();

      // Backpressure on requester 1 with requester 0 waiting
      do_reset();
      bus.resp_ready0 = 1'b1;
      bus.resp_ready1 = 1'b0;
      set_req(1'b1, 1'b1, 32'h10000, 32'h10000, 3'b101);
      wait_ready(1'b1);
      set_req(1'b1, 1'b0, '0, '0, '0);
      set_req(1'b0, 1'b1, 32'd1, 32'd2, 3'b010);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_resp_valid1", bus.resp_valid1, 1);
         chk("bp_result", bus.resp_result, 32'd0);
         chk("bp_zero", bus.resp_zero, 1);
         chk("bp_req_ready0_low", bus.req_ready0, 0);
         tick();
      end
      bus.resp_ready1 = 1'b1;
      tick();
      @(negedge clk);
      chk("bp_req0_granted", bus.req_ready0, 1);
      tick();
      set_req(1'b0, 1'b0, '0, '0, '0);
      repeat (4) tick();

      // Opcode sweep with a=3, b=0xFFFFFFFF
      for (int op = 0; op < 8; op++) begin
         run_op(1'b0, 32'd3, 32'hFFFF_FFFF, 3'(op), res, z);
         chk($sformatf("sweep_op%0d_result", op), res, sweep_exp[op]);
         chk($sformatf("sweep_op%0d_zero", op), z, 32'(sweep_exp[op] == 32'd0));
      end

      // Reset during EXEC discards the operation
      bus.resp_ready0 = 1'b1;
      set_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b010);
      wait_ready(1'b0);
      set_req(1'b0, 1'b0, '0, '0, '0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_resp_valid0", bus.resp_valid0, 0);
      chk("mid_rst_result", bus.resp_result, 0);
      chk("mid_rst_zero", bus.resp_zero, 1);
      chk("mid_rst_op_count", op_count, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      set_req(1'b1, 1'b1, 32'd5, 32'd6, 3'b000);
      @(negedge clk);
      chk("post_rst_req_ready1", bus.req_ready1, 1);
      chk("post_rst_req_ready0", bus.req_ready0, 0);
      tick();
      set_req(1'b1, 1'b0, '0, '0, '0);
      bus.resp_ready1 = 1'b1;
      wait_resp(1'b1, res, z);
      chk("post_rst_result", res, 32'd4);
      @(negedge clk);
      chk("post_rst_op_count", op_count, 1);
      tick();

      // Counter wrap with a 2-bit counter
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_op(1'(i % 2), 32'(i), 32'd1, 3'b010, res, z);
         chk($sformatf("wrap_op%0d_result", i), res, 32'(i + 1));
         @(negedge clk);
         chk($sformatf("wrap_op_count%0d", i), op_count, 32'(wrap_exp[i]));
         tick();
      end

      // Randomized traffic
      repeat (400) begin
         if (!bus.req_valid0 || got0)
            set_req(1'b0, $urandom_range(0, 2) != 0, rand_operand(), rand_operand(),
                    3'($urandom_range(0, 7)));
         if (!bus.req_valid1 || got1)
            set_req(1'b1, $urandom_range(0, 2) != 0, rand_operand(), rand_operand(),
                    3'($urandom_range(0, 7)));
         bus.resp_ready0 = ($urandom_range(0, 3) != 0);
         bus.resp_ready1 = ($urandom_range(0, 3) != 0);
         tick();
      end
      // Let the last accepted request complete before dropping the requests
      for (int i = 0; i < 10 && (bus.req_valid0 && !got0 || bus.req_valid1 && !got1); i++) tick();
      set_req(1'b0, 1'b0, '0, '0, '0);
      set_req(1'b1, 1'b0, '0, '0, '0);
      bus.resp_ready0 = 1'b1;
      bus.resp_ready1 = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      chk("final_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
